// File: rtl/semaforo_monitor.sv
// semaforo_monitor: checks two traffic-light channels (A, B) for illegal
// codes, both-non-red conflicts, bad phase sequences, over-long green/yellow
// phases and short yellow phases, and counts completed channel-A cycles.
// Optional build macro: SEMAFORO_MON_STICKY_EN (latch the first violation
// until reset instead of pulsing err per violating sample).
module semaforo_monitor #(
   parameter int YEL_MIN = 1,
   parameter int YEL_MAX = 2,
   parameter int GRN_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] A,
   input  logic [2:0] B,
   output logic       err,
   output logic [2:0] err_code,
   output logic       err_ch,
   output logic [7:0] cyc_cnt
);

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   localparam logic [3:0] YEL_MIN_L = 4'(YEL_MIN);
   localparam logic [3:0] YEL_MAX_L = 4'(YEL_MAX);
   localparam logic [3:0] GRN_MAX_L = 4'(GRN_MAX);

   localparam logic [2:0] C_ILLEGAL   = 3'd1;
   localparam logic [2:0] C_CONFLICT  = 3'd2;
   localparam logic [2:0] C_BAD_SEQ   = 3'd3;
   localparam logic [2:0] C_TIMEOUT   = 3'd4;
   localparam logic [2:0] C_YEL_SHORT = 3'd5;

   // index 0 = channel A, index 1 = channel B
   logic [1:0][2:0] prev_q, prev_d;
   logic [1:0][3:0] dur_q, dur_d;
   logic            err_q, err_d;
   logic [2:0]      err_code_q, err_code_d;
   logic            err_ch_q, err_ch_d;
   logic [7:0]      cyc_cnt_q, cyc_cnt_d;

   logic [1:0][2:0] code;
   logic [1:0]      legal, same, seq_err, tmo, ysh;
   logic            conflict;
   logic            viol;
   logic [2:0]      viol_code;
   logic            viol_ch;

   assign code = {B, A};

   // Per-channel history update and individual violation detectors
   always_comb begin
      prev_d  = prev_q;
      dur_d   = dur_q;
      legal   = '0;
      same    = '0;
      seq_err = '0;
      tmo     = '0;
      ysh     = '0;
      for (int c = 0; c < 2; c++) begin
         legal[c] = (code[c] == RED) || (code[c] == YEL) || (code[c] == GRN);
         same[c]  = (code[c] == prev_q[c]);
         // an illegal code leaves the channel history untouched
         if (legal[c]) begin
            prev_d[c] = code[c];
            if (same[c])
               dur_d[c] = (dur_q[c] == 4'd15) ? 4'd15 : dur_q[c] + 4'd1;
            else
               dur_d[c] = 4'd1;
            seq_err[c] = !same[c] &&
                         !((prev_q[c] == RED && code[c] == GRN) ||
                           (prev_q[c] == GRN && code[c] == YEL) ||
                           (prev_q[c] == YEL && code[c] == RED));
            // equality on the prior run length makes this fire once per phase
            tmo[c] = same[c] &&
                     ((code[c] == GRN && dur_q[c] == GRN_MAX_L) ||
                      (code[c] == YEL && dur_q[c] == YEL_MAX_L));
            ysh[c] = (prev_q[c] == YEL) && (code[c] == RED) &&
                     (dur_q[c] < YEL_MIN_L);
         end
      end
      conflict = legal[0] && legal[1] && (A != RED) && (B != RED);
   end

   // Pick the reported violation: lowest class first, channel A on ties
   always_comb begin
      viol      = 1'b1;
      viol_code = 3'd0;
      viol_ch   = 1'b0;
      if (!legal[0])        begin viol_code = C_ILLEGAL;   viol_ch = 1'b0; end
      else if (!legal[1])   begin viol_code = C_ILLEGAL;   viol_ch = 1'b1; end
      else if (conflict)    begin viol_code = C_CONFLICT;  viol_ch = 1'b0; end
      else if (seq_err[0])  begin viol_code = C_BAD_SEQ;   viol_ch = 1'b0; end
      else if (seq_err[1])  begin viol_code = C_BAD_SEQ;   viol_ch = 1'b1; end
      else if (tmo[0])      begin viol_code = C_TIMEOUT;   viol_ch = 1'b0; end
      else if (tmo[1])      begin viol_code = C_TIMEOUT;   viol_ch = 1'b1; end
      else if (ysh[0])      begin viol_code = C_YEL_SHORT; viol_ch = 1'b0; end
      else if (ysh[1])      begin viol_code = C_YEL_SHORT; viol_ch = 1'b1; end
      else                        viol = 1'b0;
   end

   // Output next-state: cycle counter plus error reporting policy
   always_comb begin
      cyc_cnt_d = cyc_cnt_q;
      if (legal[0] && prev_q[0] == RED && A == GRN)
         cyc_cnt_d = cyc_cnt_q + 8'd1;
      err_d      = err_q;
      err_code_d = err_code_q;
      err_ch_d   = err_ch_q;
`ifdef SEMAFORO_MON_STICKY_EN
      // first violation latches until reset
      if (!err_q && viol) begin
         err_d      = 1'b1;
         err_code_d = viol_code;
         err_ch_d   = viol_ch;
      end
`else
      err_d = viol;
      if (viol) begin
         err_code_d = viol_code;
         err_ch_d   = viol_ch;
      end
`endif
   end

   // State registers, cleared asynchronously by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q     <= {RED, RED};
         dur_q      <= '0;
         err_q      <= 1'b0;
         err_code_q <= 3'd0;
         err_ch_q   <= 1'b0;
         cyc_cnt_q  <= 8'd0;
      end else begin
         prev_q     <= prev_d;
         dur_q      <= dur_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         err_ch_q   <= err_ch_d;
         cyc_cnt_q  <= cyc_cnt_d;
      end
   end

   assign err      = err_q;
   assign err_code = err_code_q;
   assign err_ch   = err_ch_q;
   assign cyc_cnt  = cyc_cnt_q;

endmodule
